// File: rtl/pc_pkg.sv
// Shared types and helpers for the stack-capable program counter.
package pc_pkg;

  // Decoded command for one enabled cycle. OP_ERR advances like OP_INC.
  typedef enum logic [2:0] {
    OP_HOLD,
    OP_INC,
    OP_LOAD,
    OP_CALL,
    OP_RET,
    OP_ERR
  } op_t;

  // Widest counter the helper handles; callers zero-extend and truncate back.
  localparam int MAX_W           = 32;
  localparam int DEF_STACK_DEPTH = 4;
  localparam int DEPTH_W         = $clog2(DEF_STACK_DEPTH + 1);

  typedef logic [MAX_W-1:0] pc_word_t;

  // Next counter value for a decoded op. Wrap is applied by the caller's truncation.
  function automatic pc_word_t next_pc(input pc_word_t q, input op_t op,
                                       input pc_word_t d, input pc_word_t top);
    pc_word_t r;
    case (op)
      OP_INC, OP_ERR:   r = q + 1;
      OP_LOAD, OP_CALL: r = d;
      OP_RET:           r = top;
      default:          r = q;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pc_stack_counter_if.sv
// Command/status bundle between the fetch controller and the program counter.
interface pc_stack_counter_if
  import pc_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int DEPTH_W = pc_pkg::DEPTH_W
) ();
  logic               en;
  logic               load;
  logic               call;
  logic               ret;
  logic [WIDTH-1:0]   d;
  logic [WIDTH-1:0]   q;
  logic               carry;
  logic [DEPTH_W-1:0] depth;
  logic               stack_full;
  logic               stack_empty;
  logic               err;

  modport master (
    output en, load, call, ret, d,
    input  q, carry, depth, stack_full, stack_empty, err
  );

  modport slave (
    input  en, load, call, ret, d,
    output q, carry, depth, stack_full, stack_empty, err
  );
endinterface

// File: rtl/ret_stack.sv
// Return-address LIFO; top entry is read combinationally, writes on push.
module ret_stack #(
  parameter int WIDTH       = 4,
  parameter int STACK_DEPTH = 4,
  parameter int DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic [WIDTH-1:0]   din,
  output logic [WIDTH-1:0]   dout,
  output logic [DEPTH_W-1:0] depth,
  output logic               full,
  output logic               empty
);
  localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [WIDTH-1:0]   mem [2**AW];
  logic [DEPTH_W-1:0] depth_r;
  logic [AW-1:0]      wr_idx;
  logic [AW-1:0]      rd_idx;

  assign wr_idx = AW'(depth_r);
  assign rd_idx = AW'(depth_r - DEPTH_W'(1));
  assign full   = (depth_r == DEPTH_W'(STACK_DEPTH));
  assign empty  = (depth_r == '0);
  assign depth  = depth_r;
  assign dout   = mem[rd_idx];

  // Entry storage: never cleared, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (!reset && push && !full) begin
      mem[wr_idx] <= din;
    end
  end

  // Occupancy count; out-of-range push/pop are dropped here as a safety net.
  always_ff @(posedge clk) begin
    if (reset) begin
      depth_r <= '0;
    end else if (push && !full) begin
      depth_r <= depth_r + DEPTH_W'(1);
    end else if (pop && !empty) begin
      depth_r <= depth_r - DEPTH_W'(1);
    end
  end
endmodule

// File: rtl/pc_stack_counter.sv
// Program counter with jump, CALL/RET through a return stack, wrap flag and error pulse.
module pc_stack_counter
  import pc_pkg::*;
#(
  parameter int               WIDTH       = 4,
  parameter int               STACK_DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input logic               clk,
  input logic               reset,
  pc_stack_counter_if.slave bus
);
  localparam int DW = $clog2(STACK_DEPTH + 1);

  logic [WIDTH-1:0] q_r;
  logic             carry_r;
  logic             err_r;
  op_t              op;
  logic             push;
  logic             pop;
  logic             err_nxt;
  logic [WIDTH-1:0] ret_addr;
  logic [WIDTH-1:0] stk_top;
  logic [DW-1:0]    stk_depth;
  logic             stk_full;
  logic             stk_empty;

  assign ret_addr = q_r + WIDTH'(1);

  ret_stack #(
    .WIDTH       (WIDTH),
    .STACK_DEPTH (STACK_DEPTH),
    .DEPTH_W     (DW)
  ) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (ret_addr),
    .dout  (stk_top),
    .depth (stk_depth),
    .full  (stk_full),
    .empty (stk_empty)
  );

  // Priority decode: call+ret clash, then ret, then call (beats load), then load, else step.
  always_comb begin
    op      = OP_HOLD;
    push    = 1'b0;
    pop     = 1'b0;
    err_nxt = 1'b0;
    if (bus.en) begin
      if (bus.call && bus.ret) begin
        op      = OP_ERR;
        err_nxt = 1'b1;
      end else if (bus.ret) begin
        if (!stk_empty) begin
          op  = OP_RET;
          pop = 1'b1;
        end else begin
          op      = OP_ERR;
          err_nxt = 1'b1;
        end
      end else if (bus.call) begin
        if (!stk_full) begin
          op   = OP_CALL;
          push = 1'b1;
        end else begin
          op      = OP_ERR;
          err_nxt = 1'b1;
        end
      end else if (bus.load) begin
        op = OP_LOAD;
      end else begin
        op = OP_INC;
      end
    end
  end

  // Counter, wrap flag and error pulse; carry only reports a plain increment out of all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_r     <= RESET_VALUE;
      carry_r <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      err_r <= err_nxt;
      if (bus.en) begin
        q_r     <= WIDTH'(next_pc(pc_word_t'(q_r), op, pc_word_t'(bus.d), pc_word_t'(stk_top)));
        carry_r <= ((op == OP_INC) || (op == OP_ERR)) && (q_r == '1);
      end
    end
  end

  assign bus.q           = q_r;
  assign bus.carry       = carry_r;
  assign bus.err         = err_r;
  assign bus.depth       = stk_depth;
  assign bus.stack_full  = stk_full;
  assign bus.stack_empty = stk_empty;
endmodule

// File: tb/tb_pc_stack_counter.sv
// Directed scoreboard bench for pc_stack_counter (WIDTH=4, STACK_DEPTH=4).
module tb_pc_stack_counter;
  logic clk;
  logic reset;

  pc_stack_counter_if #(.WIDTH(4), .DEPTH_W(3)) bus ();

  pc_stack_counter #(
    .WIDTH       (4),
    .STACK_DEPTH (4),
    .RESET_VALUE (4'h0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0] q;
    logic       c;
    logic [2:0] dp;
    logic       e;
    string      nm;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Monitor: every edge's result is compared against the oldest pending expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.nm, ".q"},     32'(bus.q),           32'(e.q));
      chk({e.nm, ".carry"}, 32'(bus.carry),       32'(e.c));
      chk({e.nm, ".depth"}, 32'(bus.depth),       32'(e.dp));
      chk({e.nm, ".full"},  32'(bus.stack_full),  32'(e.dp == 3'd4));
      chk({e.nm, ".empty"}, 32'(bus.stack_empty), 32'(e.dp == 3'd0));
      chk({e.nm, ".err"},   32'(bus.err),         32'(e.e));
    end
  end

  // Drive one cycle of stimulus and queue the expected post-edge state.
  task automatic step(input logic r, input logic en, input logic ld, input logic ca,
                      input logic re, input logic [3:0] dd,
                      input logic [3:0] eq, input logic ec, input logic [2:0] edp,
                      input logic ee, input string nm);
    exp_t x;
    @(negedge clk);
    reset    = r;
    bus.en   = en;
    bus.load = ld;
    bus.call = ca;
    bus.ret  = re;
    bus.d    = dd;
    x.q  = eq;
    x.c  = ec;
    x.dp = edp;
    x.e  = ee;
    x.nm = nm;
    sb.push_back(x);
  endtask

  initial begin
    reset    = 1'b1;
    bus.en   = 1'b0;
    bus.load = 1'b0;
    bus.call = 1'b0;
    bus.ret  = 1'b0;
    bus.d    = 4'h0;

    //    r  en ld ca re d      q     c  dp    e
    // counting from reset
    step(1, 0, 0, 0, 0, 4'h0, 4'h0, 0, 3'd0, 0, "rst");
    step(0, 1, 0, 0, 0, 4'h0, 4'h1, 0, 3'd0, 0, "inc1");
    step(0, 1, 0, 0, 0, 4'h0, 4'h2, 0, 3'd0, 0, "inc2");
    step(0, 1, 0, 0, 0, 4'h0, 4'h3, 0, 3'd0, 0, "inc3");
    // wrap and carry
    step(0, 1, 1, 0, 0, 4'hE, 4'hE, 0, 3'd0, 0, "ldE");
    step(0, 1, 0, 0, 0, 4'h0, 4'hF, 0, 3'd0, 0, "incF");
    step(0, 1, 0, 0, 0, 4'h0, 4'h0, 1, 3'd0, 0, "wrap");
    step(0, 1, 0, 0, 0, 4'h0, 4'h1, 0, 3'd0, 0, "postwrap");
    // simple call/return
    step(0, 1, 1, 0, 0, 4'h3, 4'h3, 0, 3'd0, 0, "ld3");
    step(0, 1, 0, 1, 0, 4'hA, 4'hA, 0, 3'd1, 0, "callA");
    step(0, 1, 0, 0, 0, 4'h0, 4'hB, 0, 3'd1, 0, "incB");
    step(0, 1, 0, 0, 1, 4'h0, 4'h4, 0, 3'd0, 0, "ret4");
    // fill, overflow, drain, underflow
    step(0, 1, 0, 1, 0, 4'h8, 4'h8, 0, 3'd1, 0, "nest1");
    step(0, 1, 0, 1, 0, 4'h9, 4'h9, 0, 3'd2, 0, "nest2");
    step(0, 1, 0, 1, 0, 4'hA, 4'hA, 0, 3'd3, 0, "nest3");
    step(0, 1, 0, 1, 0, 4'hB, 4'hB, 0, 3'd4, 0, "nest4");
    step(0, 1, 0, 1, 0, 4'h0, 4'hC, 0, 3'd4, 1, "ovf");
    step(0, 1, 0, 0, 1, 4'h0, 4'hB, 0, 3'd3, 0, "pop1");
    step(0, 1, 0, 0, 1, 4'h0, 4'hA, 0, 3'd2, 0, "pop2");
    step(0, 1, 0, 0, 1, 4'h0, 4'h9, 0, 3'd1, 0, "pop3");
    step(0, 1, 0, 0, 1, 4'h0, 4'h5, 0, 3'd0, 0, "pop4");
    step(0, 1, 0, 0, 1, 4'h0, 4'h6, 0, 3'd0, 1, "udf");
    // call+ret clash, disabled cycle, load+call priority
    step(0, 1, 1, 0, 0, 4'h4, 4'h4, 0, 3'd0, 0, "ld4");
    step(0, 1, 0, 1, 0, 4'h5, 4'h5, 0, 3'd1, 0, "call5");
    step(0, 1, 0, 1, 1, 4'h9, 4'h6, 0, 3'd1, 1, "clash");
    step(0, 0, 1, 0, 0, 4'hF, 4'h6, 0, 3'd1, 0, "hold");
    step(0, 1, 1, 1, 0, 4'h2, 4'h2, 0, 3'd2, 0, "ldcall");
    // reset during a call discards it
    step(1, 1, 0, 1, 0, 4'h9, 4'h0, 0, 3'd0, 0, "rstcall");
    step(0, 1, 0, 0, 1, 4'h0, 4'h1, 0, 3'd0, 1, "retempty");
    // carry holds while disabled, cleared by a non-increment update
    step(0, 1, 1, 0, 0, 4'hE, 4'hE, 0, 3'd0, 0, "ldE2");
    step(0, 1, 0, 0, 0, 4'h0, 4'hF, 0, 3'd0, 0, "incF2");
    step(0, 1, 0, 0, 0, 4'h0, 4'h0, 1, 3'd0, 0, "wrap2");
    step(0, 0, 0, 1, 1, 4'h7, 4'h0, 1, 3'd0, 0, "holdc");
    step(0, 1, 0, 1, 0, 4'h7, 4'h7, 0, 3'd1, 0, "callclr");
    step(0, 1, 0, 0, 1, 4'h0, 4'h1, 0, 3'd0, 0, "ret1");
    // call at all-ones pushes 0 and does not set carry
    step(0, 1, 1, 0, 0, 4'hF, 4'hF, 0, 3'd0, 0, "ldF");
    step(0, 1, 0, 1, 0, 4'h2, 4'h2, 0, 3'd1, 0, "callF");
    step(0, 1, 0, 0, 1, 4'h0, 4'h0, 0, 3'd0, 0, "ret0");

    @(negedge clk);
    bus.en   = 1'b0;
    bus.load = 1'b0;
    bus.call = 1'b0;
    bus.ret  = 1'b0;
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d pending required=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pc_stack_counter.md
Name: pc_stack_counter

Overview:
Parametrised program counter, the next generation of the TD4 4-bit counter. Adds increment enable, jump load and CALL/RET support through an internal return-address LIFO. Adds a wrap (carry) flag and error reporting. Sits in the CPU fetch path and drives the instruction-ROM address.

Parameters:
WIDTH, 4, bit width of the counter, load data and stack entries (>=2)
STACK_DEPTH, 4, number of return-address entries (>=1)
RESET_VALUE, 0, value of q after reset

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
en  input  1  step enable; when 0, state holds and all commands are ignored
load  input  1  jump: q <= d
call  input  1  push return address (q+1), then q <= d
ret  input  1  pop return address into q
d  input  WIDTH  jump/call target
q  output  WIDTH  current program counter
carry  output  1  registered; 1 when the last increment wrapped from all-ones to 0
depth  output  $clog2(STACK_DEPTH+1)  number of valid stack entries
stack_full  output  1  depth == STACK_DEPTH (combinational from depth)
stack_empty  output  1  depth == 0 (combinational from depth)
err  output  1  registered one-cycle pulse on an illegal stack operation

Behaviour:
- Reset (sync, highest priority): q=RESET_VALUE, carry=0, depth=0, err=0. Stack RAM contents are not cleared. Reset mid-CALL/RET discards the operation.
- en=0: q, carry and depth hold. err=0 the next cycle. Inputs are ignored.
- en=1: the command is decoded with priority. Each result is visible on q after one edge.
  1. call && ret together: illegal. err=1. Plain increment. Stack unchanged.
  2. ret: if depth>0, q <= top entry, depth-1. If empty: err=1, plain increment.
  3. call: if depth<STACK_DEPTH, push (q+1) mod 2^WIDTH, q <= d, depth+1. If full: err=1, plain increment, no push, no jump.
  4. load: q <= d.
  5. none: q <= (q+1) mod 2^WIDTH.
- carry=1 only after a plain increment with q == all-ones. Any other update with en=1 clears it.
- err=0 in every cycle not listed above as an error.
- Return-address arithmetic is modulo 2^WIDTH. A CALL at q=all-ones pushes 0, and carry is not set by that CALL.
- load combined with call: call wins, since a call is itself a jump to d.
- Latency: one cycle for every operation. No bubbles. Back-to-back CALL/RET on consecutive cycles is supported.

Decomposition:
- Package pc_pkg:
  - op enum: OP_HOLD, OP_INC, OP_LOAD, OP_CALL, OP_RET, OP_ERR
  - function next_pc(q, op, d, top)
  - localparam DEPTH_W
- Sub-module ret_stack: synchronous LIFO of STACK_DEPTH x WIDTH.
  - Inputs: clk, reset, push, pop, din.
  - Outputs: dout (top entry, combinational), depth, full, empty.
  - ret_stack ignores a push when full and a pop when empty. The parent gates both and raises err.
- The top level holds the priority decoder, q/carry/err registers and the ret_stack instance.

Test Plan:
1. Reset then 3 cycles with en=1 -> q=0001, 0010, 0011. carry=0, depth=0.
2. From q=1110, two increments -> q=1111 (carry=0), then q=0000 with carry=1. Next increment -> q=0001, carry=0.
3. q=0011, call d=1010 -> q=1010, depth=1. Increment -> 1011. ret -> q=0100, depth=0, err=0.
4. Four nested calls (d=1000,1001,1010,1011) -> stack_full=1. Fifth call d=0000 -> err pulse one cycle, q increments (1100), depth stays 4. Four rets return 1100→… in LIFO order, then ret on empty -> err=1, q increments.
5. call and ret asserted together at q=0101 -> err=1, q=0110, depth unchanged. load with en=0 -> q holds 0110, err=0.
6. Reset asserted during a call cycle with depth=2 -> q=0000, depth=0, carry=0, err=0. Then ret -> err=1 (stack empty).
